// File: rtl/nios2_cpu_div_cell_if.sv
// ============================================================================
// Module   : nios2_cpu_div_cell_if
// Brief    : E-stage operand / M-stage result bundle for the divider cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface nios2_cpu_div_cell_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] E_src1;
    logic [DATA_WIDTH-1:0] E_src2;
    logic                  E_div_signed;
    logic                  E_div_start;
    logic                  E_div_kill;
    logic                  M_div_busy;
    logic                  M_div_done;
    logic [DATA_WIDTH-1:0] M_div_quot;
    logic [DATA_WIDTH-1:0] M_div_rem;

    modport master (
        output E_src1, E_src2, E_div_signed, E_div_start, E_div_kill,
        input  M_div_busy, M_div_done, M_div_quot, M_div_rem
    );

    modport slave (
        input  E_src1, E_src2, E_div_signed, E_div_start, E_div_kill,
        output M_div_busy, M_div_done, M_div_quot, M_div_rem
    );
endinterface

`default_nettype wire

// File: rtl/nios2_cpu_div_cell.sv
// ============================================================================
// Module   : nios2_cpu_div_cell
// Brief    : Multicycle radix-2 restoring divider for div/divu, fixed latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nios2_cpu_div_cell #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    nios2_cpu_div_cell_if.slave    div
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                 r_state;
    state_t                 w_state_next;

    logic [DATA_WIDTH-1:0]  r_src1;
    logic [DATA_WIDTH-1:0]  r_src2;
    logic                   r_signed;
    logic [DATA_WIDTH-1:0]  r_dvsr;
    logic [DATA_WIDTH-1:0]  r_part;
    logic [DATA_WIDTH-1:0]  r_quo;
    logic                   r_qsign;
    logic                   r_rsign;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_done;
    logic [DATA_WIDTH-1:0]  r_quot_out;
    logic [DATA_WIDTH-1:0]  r_rem_out;

    logic                   w_neg1;
    logic                   w_neg2;
    logic [DATA_WIDTH-1:0]  w_mag1;
    logic [DATA_WIDTH-1:0]  w_mag2;
    logic [DATA_WIDTH:0]    w_shift;
    logic [DATA_WIDTH:0]    w_trial;
    logic                   w_trial_ok;
    logic                   w_div0;
    logic                   w_accept;

    assign w_accept   = div.E_div_start & ~div.E_div_kill;
    assign w_neg1     = r_signed & r_src1[DATA_WIDTH-1];
    assign w_neg2     = r_signed & r_src2[DATA_WIDTH-1];
    assign w_mag1     = w_neg1 ? (~r_src1 + 1'b1) : r_src1;
    assign w_mag2     = w_neg2 ? (~r_src2 + 1'b1) : r_src2;

    // Partial remainder stays below the divisor, so W+1 bits hold the shifted value exactly.
    assign w_shift    = {r_part, r_quo[DATA_WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvsr};
    assign w_trial_ok = (w_shift >= {1'b0, r_dvsr});
    assign w_div0     = (r_dvsr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = PREP;
            PREP: w_state_next = div.E_div_kill ? IDLE : ITER;
            ITER: begin
                if (div.E_div_kill)          w_state_next = IDLE;
                else if (r_cnt == C_LAST_ITER) w_state_next = FIX;
            end
            FIX:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src1     <= '0;
            r_src2     <= '0;
            r_signed   <= 1'b0;
            r_dvsr     <= '0;
            r_part     <= '0;
            r_quo      <= '0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_quot_out <= '0;
            r_rem_out  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_src1   <= div.E_src1;
                        r_src2   <= div.E_src2;
                        r_signed <= div.E_div_signed;
                    end
                end
                PREP: begin
                    r_dvsr  <= w_mag2;
                    r_quo   <= w_mag1;
                    r_part  <= '0;
                    r_qsign <= w_neg1 ^ w_neg2;
                    r_rsign <= w_neg1;
                    r_cnt   <= '0;
                end
                ITER: begin
                    r_part <= w_trial_ok ? w_trial[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
                    r_quo  <= {r_quo[DATA_WIDTH-2:0], w_trial_ok};
                    r_cnt  <= r_cnt + 1'b1;
                end
                FIX: begin
                    if (!div.E_div_kill) begin
                        // Divide by zero bypasses sign fixup: all-ones quotient, raw dividend remainder.
                        r_quot_out <= (r_qsign && !w_div0) ? (~r_quo + 1'b1) : r_quo;
                        r_rem_out  <= w_div0 ? r_src1 :
                                      (r_rsign ? (~r_part + 1'b1) : r_part);
                        r_done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div.M_div_busy = (r_state != IDLE);
    assign div.M_div_done = r_done;
    assign div.M_div_quot = r_quot_out;
    assign div.M_div_rem  = r_rem_out;

endmodule

`default_nettype wire

// File: tb/tb_nios2_cpu_div_cell.sv
// ============================================================================
// Module   : tb_nios2_cpu_div_cell
// Brief    : Scoreboard bench for nios2_cpu_div_cell with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nios2_cpu_div_cell;

    logic clk;
    logic reset;
    int   cyc;
    int   t0;
    int   n_total;
    int   n_pass;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          c;
    } exp_t;

    exp_t sb[$];

    nios2_cpu_div_cell_if #(.DATA_WIDTH(32)) div_if ();

    nios2_cpu_div_cell #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .div   (div_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit push, input logic [31:0] eq, input logic [31:0] er);
        div_if.E_src1       = a;
        div_if.E_src2       = b;
        div_if.E_div_signed = s;
        div_if.E_div_start  = 1'b1;
        t0 = cyc;
        if (push) sb.push_back('{q: eq, r: er, c: t0 + 35});
        step();
        div_if.E_div_start  = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            step();
            if (div_if.M_div_done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("quot", div_if.M_div_quot, e.q);
                    chk("rem", div_if.M_div_rem, e.r);
                    chk("done_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    logic [31:0] va [7] = '{32'hFFFFFF9C, 32'd100,      32'hFFFFFF9C, 32'hFFFFFFFF,
                            32'h80000000, 32'd5,        32'hFFFFFFFB};
    logic [31:0] vb [7] = '{32'd7,        32'hFFFFFFF9, 32'hFFFFFFF9, 32'd1,
                            32'hFFFFFFFF, 32'd0,        32'd0};
    logic        vs [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] vq [7] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14,       32'hFFFFFFFF,
                            32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vr [7] = '{32'hFFFFFFFE, 32'd2,        32'hFFFFFFFE, 32'd0,
                            32'd0,        32'd5,        32'hFFFFFFFB};

    initial begin
        int t1;
        n_total = 0;
        n_pass  = 0;
        div_if.E_src1       = '0;
        div_if.E_src2       = '0;
        div_if.E_div_signed = 1'b0;
        div_if.E_div_start  = 1'b0;
        div_if.E_div_kill   = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        chk("reset_busy", 32'(div_if.M_div_busy), 32'd0);
        chk("reset_done", 32'(div_if.M_div_done), 32'd0);
        chk("reset_quot", div_if.M_div_quot, 32'd0);
        chk("reset_rem",  div_if.M_div_rem,  32'd0);
        reset = 1'b0;
        step();

        // divu 100/7 with busy window and done pulse width
        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2);
        chk("busy_first", 32'(div_if.M_div_busy), 32'd1);
        wait_to(t0 + 34);
        chk("busy_last", 32'(div_if.M_div_busy), 32'd1);
        wait_to(t0 + 35);
        chk("busy_drop", 32'(div_if.M_div_busy), 32'd0);
        chk("done_high", 32'(div_if.M_div_done), 32'd1);
        step();
        chk("done_one_cycle", 32'(div_if.M_div_done), 32'd0);
        chk("quot_hold_idle", div_if.M_div_quot, 32'd14);

        for (int i = 0; i < 7; i++) begin
            issue(va[i], vb[i], vs[i], 1'b1, vq[i], vr[i]);
            wait_to(t0 + 36);
        end

        // start while busy is ignored
        issue(32'd50, 32'd5, 1'b0, 1'b1, 32'd10, 32'd0);
        wait_to(t0 + 10);
        div_if.E_src1      = 32'd77;
        div_if.E_src2      = 32'd3;
        div_if.E_div_start = 1'b1;
        step();
        div_if.E_div_start = 1'b0;
        wait_to(t0 + 36);

        // back-to-back start in the done cycle
        issue(32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0);
        t1 = t0;
        wait_to(t1 + 35);
        issue(32'd81, 32'd9, 1'b0, 1'b1, 32'd9, 32'd0);
        wait_to(t1 + 50);
        chk("b2b_hold_quot", div_if.M_div_quot, 32'd100);
        chk("b2b_hold_rem",  div_if.M_div_rem,  32'd0);
        wait_to(t1 + 71);

        // kill mid-operation
        issue(32'd200, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_to(t0 + 20);
        div_if.E_div_kill = 1'b1;
        step();
        div_if.E_div_kill = 1'b0;
        chk("kill_busy", 32'(div_if.M_div_busy), 32'd0);
        wait_to(t0 + 45);
        chk("kill_hold_quot", div_if.M_div_quot, 32'd9);
        chk("kill_hold_rem",  div_if.M_div_rem,  32'd0);
        issue(32'd64, 32'd8, 1'b0, 1'b1, 32'd8, 32'd0);
        wait_to(t0 + 36);

        // asynchronous reset mid-operation
        issue(32'd123, 32'd4, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_to(t0 + 15);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(div_if.M_div_busy), 32'd0);
        chk("midrst_done", 32'(div_if.M_div_done), 32'd0);
        chk("midrst_quot", div_if.M_div_quot, 32'd0);
        chk("midrst_rem",  div_if.M_div_rem,  32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        issue(32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0);
        wait_to(t0 + 40);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
